// File: rtl/vend_cfg_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | vend_pkg : shared types and field layout for the vending config table    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

  localparam int PRICE_LSB = 0;
  localparam int PRICE_W   = 16;
  localparam int STOCK_LSB = 16;
  localparam int STOCK_W   = 8;
  localparam int SOLD_LSB  = 24;
  localparam int SOLD_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    WB   = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_LKP  = 2'd1,
    REQ_APB  = 2'd2
  } req_id_t;

  // One item leaves the machine: stock drops, sold count saturates at all-ones.
  function automatic logic [31:0] disp_update(input logic [31:0] entry);
    logic [SOLD_W-1:0]  sold;
    logic [STOCK_W-1:0] stock;
    logic [31:0]        res;
    sold  = entry[SOLD_LSB +: SOLD_W];
    stock = entry[STOCK_LSB +: STOCK_W];
    res   = entry;
    res[STOCK_LSB +: STOCK_W] = stock - 1'b1;
    if (sold != '1) begin
      res[SOLD_LSB +: SOLD_W] = sold + 1'b1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_cfg_sched_arb.sv
// +--------------------------------------------------------------------------+
// | vend_rr_arb : 3-requester round-robin arbiter, order disp -> lkp -> apb  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vend_rr_arb
  import vend_pkg::*;
(
  input  logic       pclk,
  input  logic       prstn,
  input  logic [2:0] req,
  input  logic       upd_en,
  output logic [2:0] grant,
  output logic [1:0] ptr
);

  logic [1:0] r_ptr;

  // Search starts one position after the last winner.
  always_comb begin
    grant = 3'b000;
    case (r_ptr)
      REQ_DISP: begin
        if      (req[REQ_LKP])  grant = 3'b010;
        else if (req[REQ_APB])  grant = 3'b100;
        else if (req[REQ_DISP]) grant = 3'b001;
      end
      REQ_LKP: begin
        if      (req[REQ_APB])  grant = 3'b100;
        else if (req[REQ_DISP]) grant = 3'b001;
        else if (req[REQ_LKP])  grant = 3'b010;
      end
      default: begin
        if      (req[REQ_DISP]) grant = 3'b001;
        else if (req[REQ_LKP])  grant = 3'b010;
        else if (req[REQ_APB])  grant = 3'b100;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_ptr <= REQ_APB;
    end else if (upd_en && (grant != 3'b000)) begin
      if (grant[REQ_DISP])     r_ptr <= REQ_DISP;
      else if (grant[REQ_LKP]) r_ptr <= REQ_LKP;
      else                     r_ptr <= REQ_APB;
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/vend_cfg_sched.sv
// +--------------------------------------------------------------------------+
// | vend_cfg_sched : item config table with single-port access scheduler     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vend_cfg_sched
  import vend_pkg::*;
#(
  parameter int          NUM_ITEMS = 64,
  parameter logic [15:0] RST_PRICE = 16'd10,
  parameter logic [7:0]  RST_STOCK = 8'd100
) (
  input  logic        pclk,
  input  logic        prstn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        disp_req,
  input  logic [5:0]  disp_code,
  output logic        disp_ack,
  output logic        disp_empty,
  input  logic        lkp_req,
  input  logic [5:0]  lkp_code,
  output logic        lkp_ack,
  output logic [15:0] lkp_price,
  output logic [7:0]  lkp_stock,
  output logic        busy
);

  localparam int          IDX_W     = $clog2(NUM_ITEMS);
  localparam logic [31:0] RST_ENTRY = {8'd0, RST_STOCK, RST_PRICE};

  sched_state_t r_state, w_next;
  req_id_t      r_owner;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             r_wr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mem [NUM_ITEMS];

  logic [2:0]       w_req;
  logic [2:0]       w_grant;
  logic [1:0]       w_rr_ptr;
  logic             w_arb_en;
  logic             w_apb_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd;
  logic             w_we;
  logic [31:0]      w_wdata;
  logic             w_unused_bits;

  assign w_req[REQ_DISP] = disp_req;
  assign w_req[REQ_LKP]  = lkp_req;
  assign w_req[REQ_APB]  = psel & penable;

  assign w_apb_err = (|paddr[31:8]) | (32'(paddr[7:2]) >= 32'(NUM_ITEMS));
  assign w_unused_bits = ^{paddr[1:0], w_rr_ptr};

  vend_rr_arb u_arb (
    .pclk   (pclk),
    .prstn  (prstn),
    .req    (w_req),
    .upd_en (w_arb_en),
    .grant  (w_grant),
    .ptr    (w_rr_ptr)
  );

  always_comb begin
    w_idx = '0;
    if (w_grant[REQ_DISP])     w_idx = disp_code[IDX_W-1:0];
    else if (w_grant[REQ_LKP]) w_idx = lkp_code[IDX_W-1:0];
    else if (w_grant[REQ_APB]) w_idx = paddr[2 +: IDX_W];
  end

  // Registered read address: the entry is valid in the cycle after the grant.
  assign w_rd = r_mem[r_idx];

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_state <= IDLE;
      r_owner <= REQ_DISP;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant != 3'b000) begin
        r_idx   <= w_idx;
        r_wr    <= pwrite;
        r_wdata <= pwdata;
        r_err   <= w_grant[REQ_APB] & w_apb_err;
        if (w_grant[REQ_DISP])     r_owner <= REQ_DISP;
        else if (w_grant[REQ_LKP]) r_owner <= REQ_LKP;
        else                       r_owner <= REQ_APB;
      end
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_mem[i] <= RST_ENTRY;
      end
    end else if (w_we) begin
      r_mem[r_idx] <= w_wdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_arb_en   = 1'b0;
    w_we       = 1'b0;
    w_wdata    = w_rd;
    prdata     = '0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    disp_ack   = 1'b0;
    disp_empty = 1'b0;
    lkp_ack    = 1'b0;
    lkp_price  = '0;
    lkp_stock  = '0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
        if (w_grant != 3'b000) w_next = DATA;
      end
      DATA: begin
        w_next = IDLE;
        case (r_owner)
          REQ_LKP: begin
            lkp_ack   = 1'b1;
            lkp_price = w_rd[PRICE_LSB +: PRICE_W];
            lkp_stock = w_rd[STOCK_LSB +: STOCK_W];
          end
          REQ_APB: begin
            pready = 1'b1;
            if (r_err) begin
              pslverr = 1'b1;
            end else if (r_wr) begin
              w_we    = 1'b1;
              w_wdata = r_wdata;
            end else begin
              prdata = w_rd;
            end
          end
          default: w_next = WB;
        endcase
      end
      WB: begin
        w_next   = IDLE;
        disp_ack = 1'b1;
        if (w_rd[STOCK_LSB +: STOCK_W] == '0) begin
          disp_empty = 1'b1;
        end else begin
          w_we    = 1'b1;
          w_wdata = disp_update(w_rd);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/vend_cfg_sched.md
Name: vend_cfg_sched

Overview:
- Owns the 64-entry item configuration table of the vending machine and schedules all accesses to it through one access port.
- Requesters: the APB host, the dispense engine and the price-lookup path.
- Each entry is 32 bits: [31:24] sold count, [23:16] stock, [15:0] price.
- Sits between the APB bus and the vending datapath. Sold/stock updates are serialized against host writes, so no entry is ever updated twice in one cycle.

Parameters:
- NUM_ITEMS, 64, number of table entries. Entry index width is log2(NUM_ITEMS).
- RST_PRICE, 16'd10, price loaded into every entry at reset.
- RST_STOCK, 8'd100, stock loaded into every entry at reset.

Ports:
- pclk  in  1  clock; all logic is in this domain.
- prstn  in  1  reset: asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  32  byte address; word index is paddr[7:2].
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- disp_req  in  1  dispense request; level signal, held until disp_ack.
- disp_code  in  6  item index to dispense.
- disp_ack  out  1  one-cycle dispense completion.
- disp_empty  out  1  valid with disp_ack; 1 = stock was 0, so nothing was dispensed.
- lkp_req  in  1  lookup request; level signal, held until lkp_ack.
- lkp_code  in  6  item index to look up.
- lkp_ack  out  1  one-cycle lookup completion.
- lkp_price  out  16  price; valid with lkp_ack.
- lkp_stock  out  8  stock; valid with lkp_ack.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (prstn low, any cycle, including mid-operation):
  - FSM goes to IDLE.
  - Every entry becomes {8'd0, RST_STOCK, RST_PRICE}.
  - All outputs are 0.
  - Round-robin pointer = APB, so dispense has first priority.
  - An in-flight transaction is dropped; requesters re-request after reset.
- Table model: register array with a registered read address, so read data appears one cycle after the address.
- FSM states:
  - IDLE: sample requests. The APB request is psel&penable. Pick a winner by round-robin in the order disp -> lkp -> apb, starting after the last grant. Latch the winner's index and drive the read address. No request: stay in IDLE.
  - DATA: read data valid.
    - Lookup: lkp_ack=1, lkp_price/lkp_stock driven, go to IDLE.
    - APB read: pready=1, prdata=entry, go to IDLE.
    - APB write: the entry takes pwdata, pready=1, go to IDLE.
    - Dispense: go to WB.
  - WB (dispense only):
    - If stock==0: entry unchanged, disp_ack=1, disp_empty=1.
    - Else: stock decrements by 1 and sold increments by 1, saturating at 8'hFF. disp_ack=1, disp_empty=0.
    - Go to IDLE.
- Latency, from the IDLE cycle that grants the request:
  - Lookup and APB complete 1 cycle later.
  - Dispense completes 2 cycles later.
- Every transaction returns to IDLE for one arbitration cycle, so back-to-back grants are spaced 2 cycles (3 cycles after a dispense).
- APB handshake:
  - pready is low in every access-phase cycle except the completion cycle.
  - prdata is 0 except in a read completion cycle.
  - Address decode error: paddr[31:8]!=0 or word index >= NUM_ITEMS. The request is completed in the next cycle with pready=1 and pslverr=1. No table access occurs; it still takes an arbitration slot.
- Requests held across a busy period are served in round-robin order. With all three requesting continuously, grants rotate disp, lkp, apb, disp, …; no requester waits more than 2 other transactions.
- A request deasserted before its ack (a protocol violation) is ignored if it drops before its grant. If it drops after the grant, the transaction still completes.
- APB write and dispense to the same entry are serialized; the later grant sees the earlier result.
- Indexes are 6 bits, so disp_code and lkp_code are never out of range when NUM_ITEMS=64.

Decomposition:
- Package vend_pkg holds:
  - Field constants: PRICE_LSB=0, PRICE_W=16, STOCK_LSB=16, STOCK_W=8, SOLD_LSB=24, SOLD_W=8.
  - Enum sched_state_t {IDLE, DATA, WB}.
  - Enum req_id_t {REQ_DISP, REQ_LKP, REQ_APB}.
- Natural sub-module: vend_rr_arb, a 3-requester round-robin arbiter. Inputs: req[2:0] and an update enable. Outputs: a one-hot grant and the updated pointer.

Test Plan:
- Reset, then APB read of index 5 -> prdata=32'h0064_000A, pready 1 cycle after the grant, pslverr=0.
- APB write of 32'h0003_0014 to index 7, then lkp_req for code 7 -> lkp_price=16'h0014, lkp_stock=8'h03.
- Three dispenses of code 7, then a fourth -> entry becomes 32'h0300_0014. The fourth returns disp_ack with disp_empty=1 and leaves the entry unchanged.
- disp_req, lkp_req and an APB read all asserted in the same cycle and held -> grant order disp, lkp, apb. Completions at relative cycles +2, +4, +6.
- Entry set to sold=8'hFF, stock=2; dispense once -> sold stays 8'hFF, stock=1.
- APB access with paddr=32'h100 -> pslverr=1 with pready and no table change. Separately, prstn pulsed low during WB -> entry back to the reset value, FSM in IDLE, no disp_ack.
